video_timing_gen: RTL

Raster timing controller that sequences the TMDS encoders of the DVI transmitter. Walks horizontal and vertical state machines through active/front-porch/sync/back-porch segments and drives `dena` and the blue-channel `ctrl` bits (`{vsync, hsync}`). Also supplies the pixel coordinates and line/frame strobes that the pixel source uses. All outputs are registered and sit in the pixel clock domain, directly in front of the three encoder instances.

---
 rtl/video_timing_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Raster timing controller for the DVI transmitter. A horizontal counter
// (hc) and a vertical counter (vc) walk the active / front-porch / sync /
// back-porch segments. All outputs are registered one clock behind the
// counters and feed the three TMDS encoders and the pixel source.
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   run          raster request, acted on only at frame boundaries
//   dena         data enable to all three encoders
//   ctrl[1:0]    {vsync, hsync} for the blue-channel encoder
//   x[CW-1:0]    pixel column of the current output cycle
//   y[CW-1:0]    line number of the current output cycle
//   line_start   one-cycle pulse when x==0
//   frame_start  one-cycle pulse when x==0 && y==0
//   busy         frame in progress
//
// Top-level FSM
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | counters held at 0, outputs at idle levels
//   ST_RUN  | counters advance every clock; leaves only after the last
//           | pixel of a frame when run is low
//
// Segment decode (same codes for horizontal and vertical)
//   seg      | meaning
//   ---------+-------------------------------------------------------------
//   SEG_ACT  | visible pixels / lines
//   SEG_FP   | front porch
//   SEG_SYNC | sync pulse
//   SEG_BP   | back porch
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          dena,
    output logic [1:0]    ctrl,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          busy
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] C_ZERO       = '0;
    localparam logic [CW-1:0] C_ONE        = CW'(1);
    localparam logic [CW-1:0] C_H_LAST     = CW'(HT - 1);
    localparam logic [CW-1:0] C_V_LAST     = CW'(VT - 1);
    localparam logic [CW-1:0] C_H_FP_S     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] C_H_SYNC_S   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] C_H_BP_S     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] C_V_FP_S     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] C_V_SYNC_S   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] C_V_BP_S     = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] SEG_ACT  = 2'd0;
    localparam logic [1:0] SEG_FP   = 2'd1;
    localparam logic [1:0] SEG_SYNC = 2'd2;
    localparam logic [1:0] SEG_BP   = 2'd3;

    logic [0:0]    r_state;
    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;

    logic          r_dena;
    logic [1:0]    r_ctrl;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_busy;

    logic [1:0]    w_h_seg;
    logic [1:0]    w_v_seg;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_hsync;
    logic          w_vsync;

    // Segment boundaries are fixed, so the segment FSMs reduce to range
    // decodes of the counters rather than separately stored state.
    always_comb begin
        w_h_seg = SEG_BP;
        if (r_hc < C_H_FP_S) begin
            w_h_seg = SEG_ACT;
        end else if (r_hc < C_H_SYNC_S) begin
            w_h_seg = SEG_FP;
        end else if (r_hc < C_H_BP_S) begin
            w_h_seg = SEG_SYNC;
        end
    end

    always_comb begin
        w_v_seg = SEG_BP;
        if (r_vc < C_V_FP_S) begin
            w_v_seg = SEG_ACT;
        end else if (r_vc < C_V_SYNC_S) begin
            w_v_seg = SEG_FP;
        end else if (r_vc < C_V_BP_S) begin
            w_v_seg = SEG_SYNC;
        end
    end

    assign w_h_last = (r_hc == C_H_LAST);
    assign w_v_last = (r_vc == C_V_LAST);
    assign w_hsync  = (w_h_seg == SEG_SYNC) ? HS_POL : ~HS_POL;
    // vsync covers whole lines: no half-line offset relative to hsync.
    assign w_vsync  = (w_v_seg == SEG_SYNC) ? VS_POL : ~VS_POL;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hc          <= C_ZERO;
            r_vc          <= C_ZERO;
            r_dena        <= 1'b0;
            r_ctrl        <= {~VS_POL, ~HS_POL};
            r_x           <= C_ZERO;
            r_y           <= C_ZERO;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hc <= C_ZERO;
                    r_vc <= C_ZERO;
                    if (run) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    if (w_h_last) begin
                        r_hc <= C_ZERO;
                        if (w_v_last) begin
                            r_vc <= C_ZERO;
                            // run is only honoured here, so a mid-frame
                            // drop always finishes the frame.
                            if (!run) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_vc <= r_vc + C_ONE;
                        end
                    end else begin
                        r_hc <= r_hc + C_ONE;
                    end
                end
            endcase

            // Outputs describe the counters of the previous cycle.
            if (r_state == ST_RUN) begin
                r_dena        <= (w_h_seg == SEG_ACT) && (w_v_seg == SEG_ACT);
                r_ctrl        <= {w_vsync, w_hsync};
                r_x           <= r_hc;
                r_y           <= r_vc;
                r_line_start  <= (r_hc == C_ZERO);
                r_frame_start <= (r_hc == C_ZERO) && (r_vc == C_ZERO);
                r_busy        <= 1'b1;
            end else begin
                r_dena        <= 1'b0;
                r_ctrl        <= {~VS_POL, ~HS_POL};
                r_x           <= C_ZERO;
                r_y           <= C_ZERO;
                r_line_start  <= 1'b0;
                r_frame_start <= 1'b0;
                r_busy        <= 1'b0;
            end
        end
    end

    assign dena        = r_dena;
    assign ctrl        = r_ctrl;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule
